// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU row scheduler.
// Pure declarations: no latency, no flow control.
package ppu_pkg;

    localparam int ROW_W        = 8;
    localparam int DEF_NUM_ROWS = 240;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MIX   = 2'd2,
        SYNC  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/ppu_row_scheduler_if.sv
// Strobe, stage-handshake and status bundle between the PPU row scheduler and its environment.
// Wires only: no latency, no backpressure.
interface ppu_row_scheduler_if
    import ppu_pkg::*;
#(
    parameter int OVR_W = 16
);

    logic             rowram_swap;
    logic             vblank_start;
    logic             vblank_end_soon;
    logic [ROW_W-1:0] next_row;

    logic             bg_start;
    logic             spr_start;
    logic [ROW_W-1:0] render_row;
    logic             bg_done;
    logic             spr_done;
    logic             mix_start;
    logic             mix_done;
    logic             row_done;

    logic             vram_sync_req;
    logic             vram_sync_ack;
    logic             sync_cut;

    logic             busy;
    logic             overrun;
    logic [OVR_W-1:0] overrun_count;

    modport master (
        input  rowram_swap, vblank_start, vblank_end_soon, next_row,
        input  bg_done, spr_done, mix_done, vram_sync_ack,
        output bg_start, spr_start, render_row, mix_start, row_done,
        output vram_sync_req, sync_cut, busy, overrun, overrun_count
    );

    modport slave (
        output rowram_swap, vblank_start, vblank_end_soon, next_row,
        output bg_done, spr_done, mix_done, vram_sync_ack,
        input  bg_start, spr_start, render_row, mix_start, row_done,
        input  vram_sync_req, sync_cut, busy, overrun, overrun_count
    );

endinterface

// File: rtl/ppu_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
// Count updates on the clock edge that samples inc; no backpressure.
module ppu_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ppu_row_scheduler.sv
// Per-row PPU scheduler: parallel bg/sprite fetch, then mix, plus a vblank VRAM sync window.
// All outputs registered (1-cycle latency from the causing input); no backpressure, late render requests are dropped and counted.
module ppu_row_scheduler
    import ppu_pkg::*;
#(
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int OVR_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    ppu_row_scheduler_if.master bus
);

    localparam logic [ROW_W:0] ROW_LIMIT = (ROW_W + 1)'(NUM_ROWS);

    sched_state_t     state, state_nxt;
    logic [ROW_W-1:0] render_row, row_nxt;
    logic             bg_seen, bg_seen_nxt;
    logic             spr_seen, spr_seen_nxt;
    logic             sync_pending, sync_pending_nxt;

    logic             start_q, start_nxt;
    logic             mix_start_q, mix_start_nxt;
    logic             row_done_q, row_done_nxt;
    logic             sync_cut_q, sync_cut_nxt;
    logic             overrun_q, overrun_nxt;
    logic             vram_sync_req_q;
    logic             busy_q;
    logic [OVR_W-1:0] overrun_count;

    logic row_ok;
    logic rreq_vld;
    logic swap_vld;
    logic vend_vld;
    logic bg_all;
    logic spr_all;

    assign row_ok   = ({1'b0, bus.next_row} < ROW_LIMIT);
    assign swap_vld = bus.rowram_swap & row_ok;
    assign vend_vld = bus.vblank_end_soon & row_ok;
    assign rreq_vld = swap_vld | vend_vld;

    // A done in the same cycle as the other stage's flag completes the pair.
    assign bg_all  = bg_seen  | bus.bg_done;
    assign spr_all = spr_seen | bus.spr_done;

    always_comb begin
        state_nxt        = state;
        row_nxt          = render_row;
        bg_seen_nxt      = bg_seen;
        spr_seen_nxt     = spr_seen;
        sync_pending_nxt = sync_pending;
        start_nxt        = 1'b0;
        mix_start_nxt    = 1'b0;
        row_done_nxt     = 1'b0;
        sync_cut_nxt     = 1'b0;
        overrun_nxt      = 1'b0;

        unique case (state)
            IDLE: begin
                if (rreq_vld) begin
                    row_nxt      = bus.next_row;
                    start_nxt    = 1'b1;
                    bg_seen_nxt  = 1'b0;
                    spr_seen_nxt = 1'b0;
                    state_nxt    = FETCH;
                    if (bus.vblank_start) begin
                        sync_pending_nxt = 1'b1;
                    end
                end else if (bus.vblank_start) begin
                    state_nxt = SYNC;
                end
            end

            FETCH: begin
                if (rreq_vld) begin
                    overrun_nxt = 1'b1;
                end
                if (bus.vblank_start) begin
                    sync_pending_nxt = 1'b1;
                end
                if (bg_all && spr_all) begin
                    bg_seen_nxt   = 1'b0;
                    spr_seen_nxt  = 1'b0;
                    mix_start_nxt = 1'b1;
                    state_nxt     = MIX;
                end else begin
                    bg_seen_nxt  = bg_all;
                    spr_seen_nxt = spr_all;
                end
            end

            MIX: begin
                if (rreq_vld) begin
                    overrun_nxt = 1'b1;
                end
                if (bus.vblank_start) begin
                    sync_pending_nxt = 1'b1;
                end
                if (bus.mix_done) begin
                    row_done_nxt = 1'b1;
                    if (sync_pending || bus.vblank_start) begin
                        sync_pending_nxt = 1'b0;
                        state_nxt        = SYNC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            SYNC: begin
                // Row 0 prefetch outranks the VRAM window.
                if (vend_vld) begin
                    row_nxt      = bus.next_row;
                    start_nxt    = 1'b1;
                    bg_seen_nxt  = 1'b0;
                    spr_seen_nxt = 1'b0;
                    sync_cut_nxt = !bus.vram_sync_ack;
                    state_nxt    = FETCH;
                end else begin
                    if (swap_vld) begin
                        overrun_nxt = 1'b1;
                    end
                    if (bus.vram_sync_ack) begin
                        state_nxt = IDLE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            render_row      <= '0;
            bg_seen         <= 1'b0;
            spr_seen        <= 1'b0;
            sync_pending    <= 1'b0;
            start_q         <= 1'b0;
            mix_start_q     <= 1'b0;
            row_done_q      <= 1'b0;
            sync_cut_q      <= 1'b0;
            overrun_q       <= 1'b0;
            vram_sync_req_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state           <= state_nxt;
            render_row      <= row_nxt;
            bg_seen         <= bg_seen_nxt;
            spr_seen        <= spr_seen_nxt;
            sync_pending    <= sync_pending_nxt;
            start_q         <= start_nxt;
            mix_start_q     <= mix_start_nxt;
            row_done_q      <= row_done_nxt;
            sync_cut_q      <= sync_cut_nxt;
            overrun_q       <= overrun_nxt;
            vram_sync_req_q <= (state_nxt == SYNC);
            busy_q          <= (state_nxt != IDLE);
        end
    end

    ppu_sat_counter #(
        .W (OVR_W)
    ) u_ovr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (overrun_nxt),
        .count (overrun_count)
    );

    assign bus.bg_start      = start_q;
    assign bus.spr_start     = start_q;
    assign bus.render_row    = render_row;
    assign bus.mix_start     = mix_start_q;
    assign bus.row_done      = row_done_q;
    assign bus.vram_sync_req = vram_sync_req_q;
    assign bus.sync_cut      = sync_cut_q;
    assign bus.busy          = busy_q;
    assign bus.overrun       = overrun_q;
    assign bus.overrun_count = overrun_count;

endmodule

// File: tb/tb_ppu_row_scheduler.sv
// Directed bench for ppu_row_scheduler with a timestamped pulse scoreboard.
module tb_ppu_row_scheduler;
    import ppu_pkg::*;

    localparam logic [6:0] SW = 7'h01;
    localparam logic [6:0] VE = 7'h02;
    localparam logic [6:0] VS = 7'h04;
    localparam logic [6:0] BD = 7'h08;
    localparam logic [6:0] SD = 7'h10;
    localparam logic [6:0] MD = 7'h20;
    localparam logic [6:0] AK = 7'h40;

    localparam int K_BG  = 0;
    localparam int K_SPR = 1;
    localparam int K_MIX = 2;
    localparam int K_RD  = 3;
    localparam int K_OVR = 4;
    localparam int K_CUT = 5;

    typedef struct {
        int          kind;
        int          c;
        logic [15:0] val;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    ppu_row_scheduler_if #(.OVR_W(16)) bus ();

    ppu_row_scheduler #(
        .NUM_ROWS (240),
        .OVR_W    (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void expect_ev(input int kind, input int dly, input logic [15:0] val);
        exp_t e;
        e.kind = kind;
        e.c    = cyc + dly;
        e.val  = val;
        exp_q.push_back(e);
    endfunction

    task automatic step(input logic [6:0] p, input logic [7:0] row);
        bus.rowram_swap     = p[0];
        bus.vblank_end_soon = p[1];
        bus.vblank_start    = p[2];
        bus.bg_done         = p[3];
        bus.spr_done        = p[4];
        bus.mix_done        = p[5];
        bus.vram_sync_ack   = p[6];
        bus.next_row        = row;
        @(negedge clk);
        bus.rowram_swap     = 1'b0;
        bus.vblank_end_soon = 1'b0;
        bus.vblank_start    = 1'b0;
        bus.bg_done         = 1'b0;
        bus.spr_done        = 1'b0;
        bus.mix_done        = 1'b0;
        bus.vram_sync_ack   = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Any pulse must match a scheduled expectation for this exact cycle, and vice versa.
    task automatic mon(input int kind, input logic pulse, input logic [15:0] obs,
                       input bit chk_val, input string tag);
        int idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].kind == kind && exp_q[i].c == cyc) idx = i;
        end
        if (pulse || idx >= 0) begin
            check(tag, 32'(pulse), 32'(idx >= 0));
            if (idx >= 0) begin
                if (chk_val && pulse) check({tag, "_val"}, 32'(obs), 32'(exp_q[idx].val));
                exp_q.delete(idx);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon(K_BG,  bus.bg_start,  16'(bus.render_row), 1'b1, "bg_start");
            mon(K_SPR, bus.spr_start, 16'(bus.render_row), 1'b1, "spr_start");
            mon(K_MIX, bus.mix_start, 16'h0,               1'b0, "mix_start");
            mon(K_RD,  bus.row_done,  16'h0,               1'b0, "row_done");
            mon(K_OVR, bus.overrun,   bus.overrun_count,   1'b1, "overrun");
            mon(K_CUT, bus.sync_cut,  16'h0,               1'b0, "sync_cut");
        end
    end

    initial begin
        int t0;
        bus.rowram_swap     = 1'b0;
        bus.vblank_end_soon = 1'b0;
        bus.vblank_start    = 1'b0;
        bus.bg_done         = 1'b0;
        bus.spr_done        = 1'b0;
        bus.mix_done        = 1'b0;
        bus.vram_sync_ack   = 1'b0;
        bus.next_row        = 8'd0;

        repeat (2) @(negedge clk);
        check("rst_busy",    32'(bus.busy),          32'd0);
        check("rst_req",     32'(bus.vram_sync_req), 32'd0);
        check("rst_row",     32'(bus.render_row),    32'd0);
        check("rst_cnt",     32'(bus.overrun_count), 32'd0);
        check("rst_bgstart", 32'(bus.bg_start),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic row with staggered dones.
        t0 = cyc;
        expect_ev(K_BG, 1, 16'd17);
        expect_ev(K_SPR, 1, 16'd17);
        step(SW, 8'd17);
        check("basic_row",  32'(bus.render_row), 32'd17);
        check("basic_busy", 32'(bus.busy),       32'd1);
        wait_cyc(t0 + 5);
        step(BD, 8'd17);
        wait_cyc(t0 + 9);
        expect_ev(K_MIX, 1, 16'd0);
        step(SD, 8'd17);
        check("basic_mix_busy", 32'(bus.busy), 32'd1);
        wait_cyc(t0 + 20);
        expect_ev(K_RD, 1, 16'd0);
        step(MD, 8'd17);
        check("basic_idle", 32'(bus.busy), 32'd0);

        // Both dones in the same cycle.
        expect_ev(K_BG, 1, 16'd5);
        expect_ev(K_SPR, 1, 16'd5);
        step(SW, 8'd5);
        expect_ev(K_MIX, 1, 16'd0);
        step(BD | SD, 8'd5);
        check("simul_busy", 32'(bus.busy), 32'd1);
        repeat (2) step(7'h0, 8'd5);
        expect_ev(K_RD, 1, 16'd0);
        step(MD, 8'd5);
        check("simul_idle", 32'(bus.busy), 32'd0);

        // Overrun during MIX.
        expect_ev(K_BG, 1, 16'd30);
        expect_ev(K_SPR, 1, 16'd30);
        step(SW, 8'd30);
        expect_ev(K_MIX, 1, 16'd0);
        step(BD | SD, 8'd30);
        expect_ev(K_OVR, 1, 16'd1);
        step(SW, 8'd31);
        check("ovr_row",  32'(bus.render_row),    32'd30);
        check("ovr_cnt1", 32'(bus.overrun_count), 32'd1);
        expect_ev(K_RD, 1, 16'd0);
        step(MD, 8'd31);

        // Drive the counter to all-ones, then one more.
        expect_ev(K_BG, 1, 16'd40);
        expect_ev(K_SPR, 1, 16'd40);
        step(SW, 8'd40);
        for (int i = 0; i < 65535; i++) begin
            int v;
            v = i + 2;
            if (v > 65535) v = 65535;
            expect_ev(K_OVR, 1, 16'(v));
            step(SW, 8'd41);
        end
        check("ovr_sat", 32'(bus.overrun_count), 32'h0000ffff);
        check("ovr_sat_row", 32'(bus.render_row), 32'd40);
        expect_ev(K_MIX, 1, 16'd0);
        step(BD | SD, 8'd40);
        expect_ev(K_RD, 1, 16'd0);
        step(MD, 8'd40);

        // vblank while busy defers the sync window.
        expect_ev(K_BG, 1, 16'd50);
        expect_ev(K_SPR, 1, 16'd50);
        step(SW, 8'd50);
        step(VS, 8'd50);
        check("vb_fetch_req", 32'(bus.vram_sync_req), 32'd0);
        expect_ev(K_MIX, 1, 16'd0);
        step(BD | SD, 8'd50);
        check("vb_mix_req", 32'(bus.vram_sync_req), 32'd0);
        expect_ev(K_RD, 1, 16'd0);
        step(MD, 8'd50);
        check("vb_sync_req", 32'(bus.vram_sync_req), 32'd1);
        check("vb_sync_busy", 32'(bus.busy), 32'd1);
        step(7'h0, 8'd50);
        check("vb_hold_req", 32'(bus.vram_sync_req), 32'd1);
        step(AK, 8'd50);
        check("vb_ack_req",  32'(bus.vram_sync_req), 32'd0);
        check("vb_ack_busy", 32'(bus.busy),          32'd0);

        // Sync window cut short by the row 0 prefetch.
        step(VS, 8'd0);
        check("cut_req_up", 32'(bus.vram_sync_req), 32'd1);
        expect_ev(K_BG, 1, 16'd0);
        expect_ev(K_SPR, 1, 16'd0);
        expect_ev(K_CUT, 1, 16'd0);
        step(VE, 8'd0);
        check("cut_req_down", 32'(bus.vram_sync_req), 32'd0);
        check("cut_row",      32'(bus.render_row),    32'd0);
        check("cut_busy",     32'(bus.busy),          32'd1);
        expect_ev(K_MIX, 1, 16'd0);
        step(BD | SD, 8'd0);
        expect_ev(K_RD, 1, 16'd0);
        step(MD, 8'd0);
        check("cut_idle", 32'(bus.busy), 32'd0);

        // rowram_swap during the sync window is an overrun.
        step(VS, 8'd0);
        expect_ev(K_OVR, 1, 16'hffff);
        step(SW, 8'd10);
        check("sync_ovr_req", 32'(bus.vram_sync_req), 32'd1);
        check("sync_ovr_row", 32'(bus.render_row),    32'd0);
        step(AK, 8'd0);
        check("sync_ovr_idle", 32'(bus.busy), 32'd0);

        // Last valid row, then out-of-range requests.
        expect_ev(K_BG, 1, 16'd239);
        expect_ev(K_SPR, 1, 16'd239);
        step(SW, 8'd239);
        expect_ev(K_MIX, 1, 16'd0);
        step(BD | SD, 8'd239);
        expect_ev(K_RD, 1, 16'd0);
        step(MD, 8'd239);
        step(SW, 8'd240);
        check("range_busy", 32'(bus.busy),       32'd0);
        check("range_row",  32'(bus.render_row), 32'd239);
        step(VE, 8'd255);
        check("range_ve_busy", 32'(bus.busy), 32'd0);

        // Async reset mid-fetch; stray dones afterwards are ignored.
        expect_ev(K_BG, 1, 16'd60);
        expect_ev(K_SPR, 1, 16'd60);
        step(SW, 8'd60);
        step(BD, 8'd60);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy),          32'd0);
        check("arst_row",  32'(bus.render_row),    32'd0);
        check("arst_cnt",  32'(bus.overrun_count), 32'd0);
        check("arst_req",  32'(bus.vram_sync_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(SD, 8'd0);
        step(BD, 8'd0);
        repeat (3) step(7'h0, 8'd0);
        check("post_rst_busy", 32'(bus.busy),       32'd0);
        check("post_rst_row",  32'(bus.render_row), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
